// File: rtl/hist_stat_mc.sv
// hist_stat_mc: multi-channel ping-pong histogram accumulator for ISP stats.
// Ports: clk, rst_n (sync, active-low); in_vsync/in_valid/in_ch/in_addr sample
// side; out_en/out_ch/out_addr/out_data back-bank read; clr_busy, hist_valid,
// frame_done status.
module hist_stat_mc #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 24,
  parameter int CH = 3,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1,
  localparam int N = CH * (2 ** ADDR_BITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vsync,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_ch,
  input  logic [ADDR_BITS-1:0] in_addr,
  input  logic                 out_en,
  input  logic [CW-1:0]        out_ch,
  input  logic [ADDR_BITS-1:0] out_addr,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 clr_busy,
  output logic                 hist_valid,
  output logic                 frame_done
);

  localparam int AW = CW + ADDR_BITS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [CW:0] CHV = (CW + 1)'(CH);
  localparam logic [DATA_BITS-1:0] MAX = '1;

  logic [DATA_BITS-1:0] mem0 [N];
  logic [DATA_BITS-1:0] mem1 [N];

  logic                 cur;
  logic                 prev_vsync;
  logic [AW-1:0]        clr_addr;
  logic                 s1_valid;
  logic                 s1_bank;
  logic [AW-1:0]        s1_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 fwd_hit;
  logic [DATA_BITS-1:0] fwd_data;

  logic                 vs_edge;
  logic                 accept;
  logic [AW-1:0]        in_a;
  logic [AW-1:0]        out_a;
  logic                 out_ok;
  logic [DATA_BITS-1:0] s1_x;
  logic [DATA_BITS-1:0] s1_wdata;
  logic                 wr_en;
  logic                 wr_bank;
  logic [AW-1:0]        wr_addr;
  logic [DATA_BITS-1:0] wr_data;

  assign vs_edge = in_vsync & ~prev_vsync;
  assign in_a    = {in_ch, in_addr};
  assign out_a   = {out_ch, out_addr};
  assign out_ok  = {1'b0, out_ch} < CHV;
  assign accept  = in_valid & ~clr_busy & ~vs_edge
                 & ({1'b0, in_ch} < CHV);

  // The previous sample's write lands on the same edge as this sample's
  // read, so a distance-1 hit takes the registered write data instead.
  always_comb begin
    s1_x     = fwd_hit ? fwd_data : rd_data;
    s1_wdata = (s1_x == MAX) ? s1_x : s1_x + 1'b1;
  end

  // Clear and accumulate never overlap: a sample accepted just before an
  // edge writes on the edge itself, one cycle before the first clear write.
  always_comb begin
    wr_en   = 1'b0;
    wr_bank = cur;
    wr_addr = clr_addr;
    wr_data = '0;
    if (rst_n) begin
      if (clr_busy) begin
        wr_en = 1'b1;
      end else if (s1_valid) begin
        wr_en   = 1'b1;
        wr_bank = s1_bank;
        wr_addr = s1_addr;
        wr_data = s1_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[wr_addr[IW-1:0]] <= wr_data;
      else         mem0[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur        <= 1'b0;
      prev_vsync <= 1'b0;
      clr_busy   <= 1'b1;
      clr_addr   <= '0;
      s1_valid   <= 1'b0;
      hist_valid <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
    end else begin
      prev_vsync <= in_vsync;
      frame_done <= vs_edge;
      s1_valid   <= accept;
      if (accept) begin
        s1_addr  <= in_a;
        s1_bank  <= cur;
        rd_data  <= cur ? mem1[in_a[IW-1:0]] : mem0[in_a[IW-1:0]];
        fwd_hit  <= s1_valid && (s1_addr == in_a) && (s1_bank == cur);
        fwd_data <= s1_wdata;
      end
      if (vs_edge) begin
        cur        <= ~cur;
        clr_busy   <= 1'b1;
        clr_addr   <= '0;
        hist_valid <= 1'b1;
      end else if (clr_busy) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == LAST) clr_busy <= 1'b0;
      end
      if (out_en) begin
        if (!out_ok)  out_data <= '0;
        else if (cur) out_data <= mem0[out_a[IW-1:0]];
        else          out_data <= mem1[out_a[IW-1:0]];
      end
    end
  end

endmodule

// File: doc/hist_stat_mc.md
# hist_stat_mc

Multi-channel, ping-pong histogram accumulator for ISP statistics (AE/AWB), the parametrised successor to the single-channel histogram collector. It bins one sample per clock into one of `CH` per-channel histograms in the current bank, while software or downstream logic reads the previous frame's bank. Compared with the single-channel collector it adds:

- channel selection;
- saturating bin counts;
- explicit clear/ready status;
- a frame-done strobe;
- a fully synchronous single-clock reset.

## Interface
Parameters:
- `ADDR_BITS`, default 8: bin index width; each channel has 2^ADDR_BITS bins.
- `DATA_BITS`, default 24: bin counter width.
- `CH`, default 3: number of channels, 1..16.
- `CW` (localparam) = max(1, clog2(CH)): channel index width.
- `N` (localparam) = CH*2^ADDR_BITS: entries per bank.

Ports:
- `clk`  in  1: single clock. All logic is posedge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_vsync`  in  1: frame sync. A rising edge swaps the banks.
- `in_valid`  in  1: sample strobe.
- `in_ch`  in  CW: channel of the sample.
- `in_addr`  in  ADDR_BITS: bin of the sample.
- `out_en`  in  1: read strobe on the back bank.
- `out_ch`  in  CW: read channel.
- `out_addr`  in  ADDR_BITS: read bin.
- `out_data`  out  DATA_BITS: read data, 1-cycle latency, held when `out_en`=0.
- `clr_busy`  out  1: current bank is being cleared.
- `hist_valid`  out  1: back bank holds a complete frame.
- `frame_done`  out  1: one-cycle pulse when a swap occurs.

## Operation
- **Storage.** Two banks, each N×DATA_BITS with 1-cycle read latency. The physical address is {ch, bin}.
- **Bank pointer.** `cur` selects the accumulating bank; the other bank is the back bank. Reset sets `cur`=0.
- **Vsync edge.** `prev_vsync` is a register. An edge is `in_vsync & ~prev_vsync`. On an edge:
  - `cur` toggles;
  - a clear of the new current bank starts at address 0;
  - `frame_done` is pulsed;
  - `hist_valid` is set to 1. It stays 1 until reset.
- **Clear.** Writes 0 to addresses 0..N-1, one per cycle, with `clr_busy`=1 throughout. Reset also starts a clear of bank 0, because RAM contents are undefined at reset.
- **Accumulate pipeline.** An accepted sample (`in_valid` & !`clr_busy` & no edge this cycle & `in_ch` < CH) runs in two stages:
  - S0: reads the current bank at {ch, bin}, and registers the address, a valid bit and the bank id.
  - S1: writes inc(x) to that same bank. x is the RAM read data, or the S1 write data of the immediately preceding sample if that sample had the same address and bank (distance-1 forwarding).
  - A distance of two or more cycles needs no forwarding.
- **Saturation.** inc(x) = x+1 if x < 2^DATA_BITS-1, else x. Counters never wrap.
- **Dropped samples.** Samples are discarded with no side effects when they arrive:
  - during a clear;
  - in the edge cycle;
  - with `in_ch` >= CH.
- **In-flight write at a swap.** An S1 write pending at the swap completes into its registered (old) bank. That bank is now the back bank, so the last sample before vsync is counted.
- **Edge during a clear.** The edge toggles `cur` again and restarts the clear at address 0 for the new current bank. The interrupted bank keeps its partial contents.
- **Reads.** The read port addresses only the back bank. It is selected from `cur` as registered in the `out_en` cycle.

## Timing
- **Reset values** (`rst_n`=0 at posedge):
  - `out_data`=0, `hist_valid`=0, `frame_done`=0, `cur`=0, `prev_vsync`=0;
  - pipeline valid = 0;
  - `clr_busy` is 1 in the first cycle after reset release and stays 1 for N cycles.
- **Mid-operation reset:** same values as above; no further RAM writes except the clear.
- **Edge sampled at posedge T:**
  - `frame_done`=1 in cycle T+1 only;
  - `clr_busy`=1 from T+1 through T+N;
  - the first sample accepted is at T+N+1.
- **Update latency:** a sample accepted at T updates RAM at the T+1 edge. It is visible to a back-bank read issued after the next swap.
- **Read latency:** `out_en` at T gives `out_data` valid at T+1.
- **Throughput:** one sample per cycle sustained, with no stalls, including back-to-back samples to the same bin.

## Test plan
- **Reset clear:** reset, wait N=768 cycles (defaults) → `clr_busy` falls exactly at cycle 769, `hist_valid`=0, `out_data`=0.
- **Counting:** frame 1 with 10 back-to-back samples ch1/bin5 plus 3 samples ch0/bin5 spaced 2 cycles apart, then a vsync edge → `frame_done` pulses once; reads return ch1/bin5=10, ch0/bin5=3, all other bins 0.
- **Forwarding:** alternating bin pattern 7,7,8,7,7 on ch2, then swap → ch2/bin7=4, ch2/bin8=1.
- **Saturation:** DATA_BITS=4, 20 samples to one bin → 15.
- **Drop rules:**
  - samples during `clr_busy`, in the edge cycle, and with `in_ch`=3 (CH=3) are not counted;
  - a sample in the cycle before the edge is counted in the old bank.
- **Edge during clear:** a second vsync edge 100 cycles into a clear → `cur` toggles back, the clear restarts, `clr_busy` lasts N cycles from the second edge, and `frame_done` pulses twice.
